// File: rtl/fetch_decode_front.sv
// ---------------------------------------------------------------------------
// fetch_decode_front
//
// RV32I instruction front end: a combinational program ROM, a fetch stage
// (program counter + instruction register) and a decode stage that registers
// the opcode, the decoded 21-bit immediate and an ALU operation class.
//
// ROM contents: small built-in demo program; words beyond it read 0.
//
// Parameters:
//   ROM_DEPTH  ROM size in 32-bit words (power of two, >= 8)
//   RESET_PC   PC loaded while in reset (word aligned)
//   ROM_FILE   hex image path (kept for interface compatibility, unused)
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   pc_src         in   1 = next PC is branch_target, 0 = PC + 4
//   branch_target  in   redirect address, bits [1:0] forced to zero
//   pc             out  current program counter (drives the ROM address)
//   instr          out  registered fetched instruction
//   opcode         out  registered instr[6:0]
//   imm            out  registered decoded immediate (21 bits)
//   alu_op         out  registered ALU operation class
// ---------------------------------------------------------------------------
module fetch_decode_front #(
    parameter int          ROM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter string       ROM_FILE  = "program.hex"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [20:0] imm,
    output logic [2:0]  alu_op
);

    localparam int AW = $clog2(ROM_DEPTH);

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ------------------------------------------------------------------
    // Program ROM (combinational read)
    // ------------------------------------------------------------------
    logic [31:0]   rom_mem [ROM_DEPTH];
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic [31:0]   pc_q, pc_d;

    function automatic logic [31:0] builtin_word(input int idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h0050_0093;
            1:       w = 32'h00A0_0113;
            2:       w = 32'h0020_81B3;
            3:       w = 32'h1234_5237;
            4:       w = 32'h0030_2023;
            5:       w = 32'h0020_8463;
            6:       w = 32'h0000_006F;
            7:       w = 32'h0000_0013;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom_word
        assign rom_mem[gi] = builtin_word(gi);
    end

    // Upper PC bits are dropped, so fetch wraps modulo ROM_DEPTH*4 bytes.
    assign rom_addr = pc_q[AW+1:2];
    assign rom_data = rom_mem[rom_addr];

    // ------------------------------------------------------------------
    // Fetch stage
    // ------------------------------------------------------------------
    logic [31:0] instr_q;

    // 32-bit add wraps naturally from 0xFFFF_FFFC to 0.
    assign pc_d = pc_src ? {branch_target[31:2], 2'b00} : pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            pc_q    <= pc_d;
            instr_q <= rom_data;
        end
    end

    // ------------------------------------------------------------------
    // Decode stage
    // ------------------------------------------------------------------
    logic [6:0]  opcode_q, opcode_d;
    logic [20:0] imm_q, imm_d;
    logic [2:0]  alu_op_q, alu_op_d;

    always_comb begin
        opcode_d = instr_q[6:0];
        imm_d    = 21'd0;
        alu_op_d = 3'b111;
        case (instr_q[6:0])
            OP_R: begin
                imm_d    = 21'd0;
                alu_op_d = 3'b010;
            end
            OP_I_ALU: begin
                imm_d    = {{9{instr_q[31]}}, instr_q[31:20]};
                alu_op_d = 3'b011;
            end
            OP_LOAD: begin
                imm_d    = {{9{instr_q[31]}}, instr_q[31:20]};
                alu_op_d = 3'b000;
            end
            OP_JALR: begin
                imm_d    = {{9{instr_q[31]}}, instr_q[31:20]};
                alu_op_d = 3'b110;
            end
            OP_STORE: begin
                imm_d    = {{9{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
                alu_op_d = 3'b000;
            end
            OP_BRANCH: begin
                imm_d    = {{8{instr_q[31]}}, instr_q[31], instr_q[7],
                            instr_q[30:25], instr_q[11:8], 1'b0};
                alu_op_d = 3'b001;
            end
            OP_LUI: begin
                imm_d    = {instr_q[31], instr_q[31:12]};
                alu_op_d = 3'b100;
            end
            OP_AUIPC: begin
                imm_d    = {instr_q[31], instr_q[31:12]};
                alu_op_d = 3'b101;
            end
            OP_JAL: begin
                imm_d    = {instr_q[31], instr_q[19:12], instr_q[20],
                            instr_q[30:21], 1'b0};
                alu_op_d = 3'b110;
            end
            default: begin
                imm_d    = 21'd0;
                alu_op_d = 3'b111;
            end
        endcase
    end

    // Reset values match the decode of the NOP held in instr while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= OP_I_ALU;
            imm_q    <= 21'd0;
            alu_op_q <= 3'b011;
        end else begin
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign pc     = pc_q;
    assign instr  = instr_q;
    assign opcode = opcode_q;
    assign imm    = imm_q;
    assign alu_op = alu_op_q;

endmodule

// File: tb/tb_fetch_decode_front.sv
module tb_fetch_decode_front;

    logic        clk;
    logic        rst_n;
    logic        pc_src;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [20:0] imm;
    logic [2:0]  alu_op;

    int n_checks;
    int n_errors;

    fetch_decode_front #(
        .ROM_DEPTH (256),
        .RESET_PC  (32'h0000_0000),
        .ROM_FILE  ("program.hex")
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .pc            (pc),
        .instr         (instr),
        .opcode        (opcode),
        .imm           (imm),
        .alu_op        (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Hand-written built-in image; words 8.. are zero.
    function automatic logic [31:0] exp_word(input int idx);
        case (idx)
            0:       return 32'h0050_0093;
            1:       return 32'h00A0_0113;
            2:       return 32'h0020_81B3;
            3:       return 32'h1234_5237;
            4:       return 32'h0030_2023;
            5:       return 32'h0020_8463;
            6:       return 32'h0000_006F;
            7:       return 32'h0000_0013;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Hand-decoded expectations {opcode, imm, alu_op} for each image word.
    task automatic exp_decode(input int idx, output logic [6:0] op, output logic [20:0] im,
                              output logic [2:0] al);
        case (idx)
            0: begin op = 7'b0010011; im = 21'd5;       al = 3'b011; end
            1: begin op = 7'b0010011; im = 21'd10;      al = 3'b011; end
            2: begin op = 7'b0110011; im = 21'd0;       al = 3'b010; end
            3: begin op = 7'b0110111; im = 21'h12345;   al = 3'b100; end
            4: begin op = 7'b0100011; im = 21'd0;       al = 3'b000; end
            5: begin op = 7'b1100011; im = 21'd8;       al = 3'b001; end
            6: begin op = 7'b1101111; im = 21'd0;       al = 3'b110; end
            7: begin op = 7'b0010011; im = 21'd0;       al = 3'b011; end
            default: begin op = 7'b0000000; im = 21'd0; al = 3'b111; end
        endcase
    endtask

    task automatic check_decode(input string tag, input int idx);
        logic [6:0]  op;
        logic [20:0] im;
        logic [2:0]  al;
        exp_decode(idx, op, im, al);
        check_eq({tag, ".opcode"}, 32'(opcode), 32'(op));
        check_eq({tag, ".imm"},    32'(imm),    32'(im));
        check_eq({tag, ".alu_op"}, 32'(alu_op), 32'(al));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".pc"},     pc,           32'h0000_0000);
        check_eq({tag, ".instr"},  instr,        32'h0000_0013);
        check_eq({tag, ".opcode"}, 32'(opcode),  32'h0000_0013);
        check_eq({tag, ".imm"},    32'(imm),     32'h0000_0000);
        check_eq({tag, ".alu_op"}, 32'(alu_op),  32'h0000_0003);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        pc_src        = 1'b0;
        branch_target = 32'h0;

        #12;
        check_reset_state("reset");
        $display("txn reset: pc=%08h instr=%08h", pc, instr);

        @(negedge clk);
        rst_n = 1'b1;

        // Sequential run through the image and past the ROM end (wrap).
        for (int k = 1; k <= 258; k++) begin
            step();
            check_eq($sformatf("seq%0d.pc", k), pc, 32'(4 * k));
            check_eq($sformatf("seq%0d.instr", k), instr, exp_word((k - 1) % 256));
            if (k >= 2)
                check_decode($sformatf("seq%0d", k), (k - 2) % 256);
            else
                check_decode("seq1", 7); // still decoding the reset NOP
            if (k <= 10 || k >= 256)
                $display("txn seq edge %0d: pc=%08h instr=%08h op=%07b imm=%06h alu=%03b",
                         k, pc, instr, opcode, imm, alu_op);
        end

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        $display("txn async reset: pc=%08h instr=%08h", pc, instr);
        step();
        check_reset_state("rst_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Redirect to 0x13 -> 0x10, then fetch of word 4.
        step();
        check_eq("br1.pc", pc, 32'h4);
        check_eq("br1.instr", instr, exp_word(0));
        pc_src        = 1'b1;
        branch_target = 32'h0000_0013;
        step();
        check_eq("br2.pc", pc, 32'h10);
        check_eq("br2.instr", instr, exp_word(1));
        $display("txn redirect 0x13: pc=%08h", pc);
        pc_src = 1'b0;
        step();
        check_eq("br3.pc", pc, 32'h14);
        check_eq("br3.instr", instr, 32'h0030_2023);
        step();
        check_decode("br4", 4);
        check_eq("br4.instr", instr, exp_word(5));
        $display("txn after redirect: pc=%08h instr=%08h op=%07b", pc, instr, opcode);

        // Redirect to top of address space, then 32-bit wrap to 0.
        pc_src        = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        check_eq("top.pc", pc, 32'hFFFF_FFFC);
        check_eq("top.instr", instr, exp_word(6));
        pc_src = 1'b0;
        step();
        check_eq("wrap.pc", pc, 32'h0);
        check_eq("wrap.instr", instr, 32'h0); // word 255
        check_decode("wrap", 6);
        step();
        check_eq("wrap2.pc", pc, 32'h4);
        check_eq("wrap2.instr", instr, exp_word(0));
        check_decode("wrap2", 8); // unknown opcode 0
        $display("txn pc wrap: pc=%08h instr=%08h op=%07b alu=%03b", pc, instr, opcode, alu_op);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
